id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline boundary of the 5-stage MIPS core. Registers decoded operands, immediates, register numbers and control bits into the execute stage. Detects load-use and branch-compare hazards and drives the stall and flush controls. Produces the ForwardAE/ForwardBE selects and the RD1E/RD2E operands consumed directly by the execute-stage forwarding muxes.

## Interface
Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock for the whole block.
- reset  in  1  asynchronous, active-high; clears every register.
- RD1D, RD2D  in  32  register-file read data from decode.
- SignImmD  in  32  sign-extended immediate.
- RsD, RtD, RdD  in  5  register numbers from decode.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control.
- ALUControlD  in  3  ALU operation.
- BranchD  in  1  decode holds a beq/bne.
- RegWriteM, MemtoRegM  in  1  memory-stage control.
- WriteRegM, WriteRegW  in  5  destination registers in M and W.
- RegWriteW  in  1  writeback enable.
- RD1E, RD2E, SignImmE  out  32  registered operands.
- RsE, RtE, RdE  out  5  registered register numbers.
- WriteRegE  out  5  RegDstE ? RdE : RtE.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  out  1  registered control.
- ALUControlE  out  3  registered ALU operation.
- ForwardAE, ForwardBE  out  2  execute operand selects.
- ForwardAD, ForwardBD  out  1  decode branch-comparator forward from M.
- StallF, StallD, FlushE  out  1  hazard controls.
- BubbleCnt  out  CNT_W  number of bubbles inserted since reset.

## Operation
- Normal cycle: every D input is captured into its E register on the clock edge.
- lwstall = MemtoRegE & ((RtE == RsD) | (RtE == RtD)).
- branchstall = BranchD & ((RegWriteE & WriteRegE ∈ {RsD, RtD}) | (MemtoRegM & WriteRegM ∈ {RsD, RtD})).
- StallF = StallD = FlushE = lwstall | branchstall.
- When FlushE = 1 at the edge, all E registers load 0 (bubble): data, register numbers and control.
- A bubble has RegWriteE = MemtoRegE = MemWriteE = 0, so it cannot create a further hazard.
- ForwardAE:
  - 2'b10 if RsE != 0 & RegWriteM & RsE == WriteRegM;
  - else 2'b01 if RsE != 0 & RegWriteW & RsE == WriteRegW;
  - else 2'b00.
  - Never 2'b11.
- ForwardBE: same rules using RtE.
- M has priority over W when both match.
- ForwardAD = (RsD != 0) & RegWriteM & (RsD == WriteRegM). ForwardBD: same rules using RtD.
- BubbleCnt increments by 1 on each edge where FlushE = 1. It saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous, immediate): all E outputs 0, BubbleCnt 0.
  - Consequently ForwardAE = ForwardBE = 2'b00 and StallF = StallD = FlushE = 0, unless M/W/D inputs alone create a match.
- E-register latency: 1 cycle, D to E.
- Forward, stall and flush outputs are combinational from current E registers and M/W/D inputs; there is no added latency.
- Load-use: exactly one bubble. On the following cycle the load sits in M with MemtoRegE = 0, so the stall releases.
- Branch after ALU producer: one stall cycle. Branch after load: two stall cycles (E match, then M match).
- lwstall and branchstall together produce a single flush; BubbleCnt increments by 1, not 2.
- Register $0 never forwards and never matches for forwarding. Stall matches on $0 are allowed; they are conservative and harmless.
- Reset asserted mid-stall: registers clear immediately. The first edge after release captures normally unless a hazard is present.

## Structure
- mips_pkg holds:
  - forward encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - ALU control width 3;
  - register-number width 5.
- One combinational sub-module, hazard_unit, computes lwstall, branchstall and the four forward selects.
- id_ex_stage instantiates hazard_unit and owns the E registers and BubbleCnt.

## Test plan
- Reset: assert reset with random D inputs → all E outputs 0, BubbleCnt = 0. Release, RD1D = 32'h1234 → RD1E = 32'h1234 one edge later.
- Load-use: lw $8 in E (MemtoRegE = 1, RtE = 8); decode add with RsD = 8 → StallF = StallD = FlushE = 1. Next cycle: E control all 0, BubbleCnt = 1, stall released.
- Forward priority: RsE = 5, RegWriteM = 1, WriteRegM = 5, RegWriteW = 1, WriteRegW = 5 → ForwardAE = 2'b10. Drop RegWriteM → 2'b01.
- $0 guard: RsE = 0, WriteRegM = 0, RegWriteM = 1 → ForwardAE = 2'b00. RsD = 0 with the same M state → ForwardAD = 0.
- Branch after load: BranchD = 1, RsD = 9, lw to $9 in E → 2 consecutive stall cycles, BubbleCnt += 2. Then ForwardAD = 0 once the load reaches W.
- Saturation: CNT_W = 4, hold a load-use hazard for 20 cycles → BubbleCnt stops at 4'hF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, forward encodings and the ID/EX register payload for the MIPS core.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Everything the execute stage receives from decode, held in one register.
  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic [ALU_W-1:0]  alu_control;
  } ex_regs_t;

  // Operand source select; the memory stage wins over writeback and $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             rw_m,
                                         input logic [REG_W-1:0] wr_m,
                                         input logic             rw_w,
                                         input logic [REG_W-1:0] wr_w);
    if ((src != '0) && rw_m && (src == wr_m)) return FWD_MEM;
    if ((src != '0) && rw_w && (src == wr_w)) return FWD_WB;
    return FWD_RF;
  endfunction

  // True when a destination register collides with either decode source.
  function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (dst == rs) || (dst == rt);
  endfunction

endpackage

// File: rtl/id_ex_if.sv
// Decode/memory/writeback inputs and execute-stage outputs of the ID/EX boundary.
interface id_ex_if import mips_pkg::*; #(parameter int unsigned CNT_W = 16);

  logic [DATA_W-1:0] RD1D, RD2D, SignImmD;
  logic [REG_W-1:0]  RsD, RtD, RdD;
  logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [ALU_W-1:0]  ALUControlD;
  logic              BranchD;
  logic              RegWriteM, MemtoRegM;
  logic [REG_W-1:0]  WriteRegM, WriteRegW;
  logic              RegWriteW;

  logic [DATA_W-1:0] RD1E, RD2E, SignImmE;
  logic [REG_W-1:0]  RsE, RtE, RdE, WriteRegE;
  logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [ALU_W-1:0]  ALUControlE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              StallF, StallD, FlushE;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output RD1D, RD2D, SignImmD, RsD, RtD, RdD,
           RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, BranchD,
           RegWriteM, MemtoRegM, WriteRegM, WriteRegW, RegWriteW,
    input  RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, BubbleCnt
  );

  modport slave (
    input  RD1D, RD2D, SignImmD, RsD, RtD, RdD,
           RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, BranchD,
           RegWriteM, MemtoRegM, WriteRegM, WriteRegW, RegWriteW,
    output RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, BubbleCnt
  );

endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use / branch hazard detection and forward-select generation.
module hazard_unit import mips_pkg::*; (
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             branch_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic             reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_w,
  output logic             lwstall_c,
  output logic             branchstall_c,
  output logic [1:0]       fwd_ae_c,
  output logic [1:0]       fwd_be_c,
  output logic             fwd_ad_c,
  output logic             fwd_bd_c
);

  // Stall detection; $0 collisions are allowed to stall, which is merely conservative.
  always_comb begin
    lwstall_c     = mem_to_reg_e & src_hit(rt_e, rs_d, rt_d);
    branchstall_c = branch_d &
                    ((reg_write_e & src_hit(write_reg_e, rs_d, rt_d)) |
                     (mem_to_reg_m & src_hit(write_reg_m, rs_d, rt_d)));
  end

  // Execute operand selects and decode branch-comparator forwards from M.
  always_comb begin
    fwd_ae_c = fwd_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_be_c = fwd_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_ad_c = (rs_d != '0) & reg_write_m & (rs_d == write_reg_m);
    fwd_bd_c = (rt_d != '0) & reg_write_m & (rt_d == write_reg_m);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard-driven bubble insertion and a saturating bubble counter.
module id_ex_stage import mips_pkg::*; #(
  parameter int unsigned CNT_W = 16
) (
  input  logic    clk,
  input  logic    reset,
  id_ex_if.slave  bus
);

  ex_regs_t         e_q;
  ex_regs_t         e_d;
  logic [CNT_W-1:0] bubble_q;
  logic [REG_W-1:0] write_reg_e_c;
  logic             lwstall_c;
  logic             branchstall_c;
  logic             flush_c;
  logic [1:0]       fwd_ae_c;
  logic [1:0]       fwd_be_c;
  logic             fwd_ad_c;
  logic             fwd_bd_c;

  assign write_reg_e_c = e_q.reg_dst ? e_q.rd : e_q.rt;
  assign flush_c       = lwstall_c | branchstall_c;

  hazard_unit u_hazard (
    .rs_d          (bus.RsD),
    .rt_d          (bus.RtD),
    .branch_d      (bus.BranchD),
    .rs_e          (e_q.rs),
    .rt_e          (e_q.rt),
    .write_reg_e   (write_reg_e_c),
    .reg_write_e   (e_q.reg_write),
    .mem_to_reg_e  (e_q.mem_to_reg),
    .write_reg_m   (bus.WriteRegM),
    .reg_write_m   (bus.RegWriteM),
    .mem_to_reg_m  (bus.MemtoRegM),
    .write_reg_w   (bus.WriteRegW),
    .reg_write_w   (bus.RegWriteW),
    .lwstall_c     (lwstall_c),
    .branchstall_c (branchstall_c),
    .fwd_ae_c      (fwd_ae_c),
    .fwd_be_c      (fwd_be_c),
    .fwd_ad_c      (fwd_ad_c),
    .fwd_bd_c      (fwd_bd_c)
  );

  // Next E contents: decode payload, or an all-zero bubble when flushing.
  always_comb begin
    e_d = '0;
    if (!flush_c) begin
      e_d.rd1         = bus.RD1D;
      e_d.rd2         = bus.RD2D;
      e_d.imm         = bus.SignImmD;
      e_d.rs          = bus.RsD;
      e_d.rt          = bus.RtD;
      e_d.rd          = bus.RdD;
      e_d.reg_write   = bus.RegWriteD;
      e_d.mem_to_reg  = bus.MemtoRegD;
      e_d.mem_write   = bus.MemWriteD;
      e_d.alu_src     = bus.ALUSrcD;
      e_d.reg_dst     = bus.RegDstD;
      e_d.alu_control = bus.ALUControlD;
    end
  end

  // E pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  // Bubble counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_q <= '0;
    else if (flush_c && (bubble_q != {CNT_W{1'b1}}))
      bubble_q <= bubble_q + CNT_W'(1);
  end

  // Drive the execute-side view of the interface.
  always_comb begin
    bus.RD1E        = e_q.rd1;
    bus.RD2E        = e_q.rd2;
    bus.SignImmE    = e_q.imm;
    bus.RsE         = e_q.rs;
    bus.RtE         = e_q.rt;
    bus.RdE         = e_q.rd;
    bus.WriteRegE   = write_reg_e_c;
    bus.RegWriteE   = e_q.reg_write;
    bus.MemtoRegE   = e_q.mem_to_reg;
    bus.MemWriteE   = e_q.mem_write;
    bus.ALUSrcE     = e_q.alu_src;
    bus.ALUControlE = e_q.alu_control;
    bus.ForwardAE   = fwd_ae_c;
    bus.ForwardBE   = fwd_be_c;
    bus.ForwardAD   = fwd_ad_c;
    bus.ForwardBD   = fwd_bd_c;
    bus.StallF      = flush_c;
    bus.StallD      = flush_c;
    bus.FlushE      = flush_c;
    bus.BubbleCnt   = bubble_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: pipeline capture, forwarding, stalls, bubbles, saturation.
module tb_id_ex_stage;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_if #(.CNT_W(CW)) bus ();
  id_ex_stage #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] rd1;
    logic [4:0]  rs, rt, rd;
    logic        rw, mtr, rdst, br;
    logic        rwm, mtrm;
    logic [4:0]  wrm;
    logic        rww;
    logic [4:0]  wrw;
    logic        stall;
    logic [1:0]  fae, fbe;
    logic        fad, fbd;
    logic [31:0] rd1e;
    logic [4:0]  rse, rte, wre;
    logic        rwe, mtre;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic [31:0] rd1, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic rw, input logic mtr, input logic rdst, input logic br,
      input logic rwm, input logic mtrm, input logic [4:0] wrm, input logic rww, input logic [4:0] wrw,
      input logic stall, input logic [1:0] fae, input logic [1:0] fbe, input logic fad, input logic fbd,
      input logic [31:0] rd1e, input logic [4:0] rse, input logic [4:0] rte, input logic [4:0] wre,
      input logic rwe, input logic mtre, input logic [3:0] cnt);
    vec_t v;
    v.rd1 = rd1; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rw = rw; v.mtr = mtr; v.rdst = rdst; v.br = br;
    v.rwm = rwm; v.mtrm = mtrm; v.wrm = wrm; v.rww = rww; v.wrw = wrw;
    v.stall = stall; v.fae = fae; v.fbe = fbe; v.fad = fad; v.fbd = fbd;
    v.rd1e = rd1e; v.rse = rse; v.rte = rte; v.wre = wre;
    v.rwe = rwe; v.mtre = mtre; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    bus.RD1D = v.rd1; bus.RD2D = ~v.rd1; bus.SignImmD = v.rd1 + 32'd1;
    bus.RsD = v.rs; bus.RtD = v.rt; bus.RdD = v.rd;
    bus.RegWriteD = v.rw; bus.MemtoRegD = v.mtr; bus.RegDstD = v.rdst; bus.BranchD = v.br;
    bus.MemWriteD = 1'b0; bus.ALUSrcD = 1'b1; bus.ALUControlD = v.rd[2:0];
    bus.RegWriteM = v.rwm; bus.MemtoRegM = v.mtrm; bus.WriteRegM = v.wrm;
    bus.RegWriteW = v.rww; bus.WriteRegW = v.wrw;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, " StallF"}, 32'(bus.StallF), 32'(exp));
    chk({name, " StallD"}, 32'(bus.StallD), 32'(exp));
    chk({name, " FlushE"}, 32'(bus.FlushE), 32'(exp));
  endtask

  initial begin
    vec_t  v;
    string n;

    // columns: rd1 rs rt rd | rw mtr rdst br | rwm mtrm wrm rww wrw | stall fae fbe fad fbd | rd1e rse rte wre rwe mtre cnt
    vecs.push_back(mk(32'h1234, 1, 2, 3,  1,0,1,0,  0,0,0, 0,0,  0,2'b00,2'b00,0,0,  32'h1234, 1, 2, 3, 1,0, 0));
    vecs.push_back(mk(32'h0100, 4, 8, 0,  1,1,0,0,  1,0,1, 0,0,  0,2'b10,2'b00,0,0,  32'h0100, 4, 8, 8, 1,1, 0));
    vecs.push_back(mk(32'h0200, 8, 9,10,  1,0,1,0,  0,0,0, 1,1,  1,2'b00,2'b00,0,0,  32'h0000, 0, 0, 0, 0,0, 1));
    vecs.push_back(mk(32'h0200, 8, 9,10,  1,0,1,0,  1,1,8, 0,0,  0,2'b00,2'b00,1,0,  32'h0200, 8, 9,10, 1,0, 1));
    vecs.push_back(mk(32'h0300, 5, 6, 7,  1,0,1,0,  1,0,8, 1,9,  0,2'b10,2'b01,0,0,  32'h0300, 5, 6, 7, 1,0, 1));
    vecs.push_back(mk(32'h0400, 5, 6, 7,  1,0,1,0,  1,0,5, 1,5,  0,2'b10,2'b00,1,0,  32'h0400, 5, 6, 7, 1,0, 1));
    vecs.push_back(mk(32'h0500, 0, 0, 0,  0,0,0,0,  0,0,5, 1,5,  0,2'b01,2'b00,0,0,  32'h0500, 0, 0, 0, 0,0, 1));
    vecs.push_back(mk(32'h0600, 0, 0, 0,  0,0,0,0,  1,0,0, 1,0,  0,2'b00,2'b00,0,0,  32'h0600, 0, 0, 0, 0,0, 1));
    vecs.push_back(mk(32'h0700, 1, 9, 0,  1,1,0,0,  0,0,0, 0,0,  0,2'b00,2'b00,0,0,  32'h0700, 1, 9, 9, 1,1, 1));
    vecs.push_back(mk(32'h0800, 9, 3, 0,  0,0,0,1,  0,0,0, 0,0,  1,2'b00,2'b00,0,0,  32'h0000, 0, 0, 0, 0,0, 2));
    vecs.push_back(mk(32'h0800, 9, 3, 0,  0,0,0,1,  1,1,9, 0,0,  1,2'b00,2'b00,1,0,  32'h0000, 0, 0, 0, 0,0, 3));
    vecs.push_back(mk(32'h0800, 9, 3, 0,  0,0,0,1,  0,0,0, 1,9,  0,2'b00,2'b00,0,0,  32'h0800, 9, 3, 3, 0,0, 3));
    vecs.push_back(mk(32'h0900, 0, 0, 0,  0,0,0,0,  0,0,0, 1,9,  0,2'b01,2'b00,0,0,  32'h0900, 0, 0, 0, 0,0, 3));
    vecs.push_back(mk(32'h0A00, 0, 4, 0,  1,1,0,0,  0,0,0, 0,0,  0,2'b00,2'b00,0,0,  32'h0A00, 0, 4, 4, 1,1, 3));
    vecs.push_back(mk(32'h0B00, 2, 4, 5,  1,0,1,0,  0,0,0, 0,0,  1,2'b00,2'b00,0,0,  32'h0000, 0, 0, 0, 0,0, 4));
    vecs.push_back(mk(32'h0B00, 2, 4, 5,  1,0,1,0,  1,0,4, 0,0,  0,2'b00,2'b00,0,1,  32'h0B00, 2, 4, 5, 1,0, 4));
    vecs.push_back(mk(32'h0C00, 0, 0, 0,  0,0,0,0,  1,0,4, 1,2,  0,2'b01,2'b10,0,0,  32'h0C00, 0, 0, 0, 0,0, 4));

    // Reset with random decode inputs clears every E register and the counter.
    reset = 1'b1;
    bus.RD1D = $urandom; bus.RD2D = $urandom; bus.SignImmD = $urandom;
    bus.RsD = 5'($urandom); bus.RtD = 5'($urandom); bus.RdD = 5'($urandom);
    bus.RegWriteD = 1'b1; bus.MemtoRegD = 1'b1; bus.MemWriteD = 1'b1;
    bus.ALUSrcD = 1'b1; bus.RegDstD = 1'b1; bus.ALUControlD = 3'($urandom); bus.BranchD = 1'b0;
    bus.RegWriteM = 1'b0; bus.MemtoRegM = 1'b0; bus.WriteRegM = '0;
    bus.RegWriteW = 1'b0; bus.WriteRegW = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst RD1E", bus.RD1E, 32'h0);
    chk("rst RD2E", bus.RD2E, 32'h0);
    chk("rst RegWriteE", 32'(bus.RegWriteE), 32'h0);
    chk("rst MemtoRegE", 32'(bus.MemtoRegE), 32'h0);
    chk("rst WriteRegE", 32'(bus.WriteRegE), 32'h0);
    chk("rst ForwardAE", 32'(bus.ForwardAE), 32'h0);
    chk("rst BubbleCnt", 32'(bus.BubbleCnt), 32'h0);
    chk_stall("rst", 1'b0);

    // Release and capture one instruction into E.
    @(negedge clk);
    reset = 1'b0;
    bus.RD1D = 32'h1234; bus.RD2D = 32'h55AA; bus.SignImmD = 32'hFFFF_FFF0;
    bus.RsD = '0; bus.RtD = '0; bus.RdD = '0;
    bus.RegWriteD = 1'b0; bus.MemtoRegD = 1'b0; bus.MemWriteD = 1'b1;
    bus.ALUSrcD = 1'b1; bus.RegDstD = 1'b0; bus.ALUControlD = 3'b110;
    @(posedge clk);
    #1;
    chk("rel RD1E", bus.RD1E, 32'h1234);
    chk("rel RD2E", bus.RD2E, 32'h55AA);
    chk("rel SignImmE", bus.SignImmE, 32'hFFFF_FFF0);
    chk("rel ALUControlE", 32'(bus.ALUControlE), 32'h6);
    chk("rel MemWriteE", 32'(bus.MemWriteE), 32'h1);
    chk("rel ALUSrcE", 32'(bus.ALUSrcE), 32'h1);

    // Table: combinational controls before each edge, E registers after it.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      n = $sformatf("v%0d", i);
      @(negedge clk);
      drive_vec(v);
      #2;
      chk_stall(n, v.stall);
      chk({n, " ForwardAE"}, 32'(bus.ForwardAE), 32'(v.fae));
      chk({n, " ForwardBE"}, 32'(bus.ForwardBE), 32'(v.fbe));
      chk({n, " ForwardAD"}, 32'(bus.ForwardAD), 32'(v.fad));
      chk({n, " ForwardBD"}, 32'(bus.ForwardBD), 32'(v.fbd));
      @(posedge clk);
      #1;
      chk({n, " RD1E"}, bus.RD1E, v.rd1e);
      chk({n, " RsE"}, 32'(bus.RsE), 32'(v.rse));
      chk({n, " RtE"}, 32'(bus.RtE), 32'(v.rte));
      chk({n, " WriteRegE"}, 32'(bus.WriteRegE), 32'(v.wre));
      chk({n, " RegWriteE"}, 32'(bus.RegWriteE), 32'(v.rwe));
      chk({n, " MemtoRegE"}, 32'(bus.MemtoRegE), 32'(v.mtre));
      chk({n, " BubbleCnt"}, 32'(bus.BubbleCnt), 32'(v.cnt));
    end

    // Reset asserted while a load-use stall is pending clears state immediately.
    @(negedge clk);
    drive_vec(mk(32'h0D00, 0, 8, 0, 1,1,0,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0));
    @(negedge clk);
    drive_vec(mk(32'h0E00, 8, 9, 10, 1,0,1,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0));
    #2;
    chk_stall("mid pre", 1'b1);
    reset = 1'b1;
    #1;
    chk("mid MemtoRegE", 32'(bus.MemtoRegE), 32'h0);
    chk("mid RD1E", bus.RD1E, 32'h0);
    chk("mid BubbleCnt", 32'(bus.BubbleCnt), 32'h0);
    chk_stall("mid rst", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid cap RD1E", bus.RD1E, 32'h0E00);
    chk("mid cap RsE", 32'(bus.RsE), 32'h8);
    chk("mid cap BubbleCnt", 32'(bus.BubbleCnt), 32'h0);

    // Persistent branch-after-load hazard: counter climbs and saturates at all-ones.
    @(negedge clk);
    drive_vec(mk(32'h0F00, 9, 3, 0, 0,0,0,1, 1,1,9, 0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 14) chk("sat BubbleCnt@14", 32'(bus.BubbleCnt), 32'hE);
    end
    chk("sat BubbleCnt@20", 32'(bus.BubbleCnt), 32'hF);
    chk_stall("sat", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
